// File: rtl/operand_select_ctrl.sv
// ----------------------------------------------------------------------------
// operand_select_ctrl
//
// Sequencing controller wrapped around an 8-bit 4:1 operand multiplexer.
// Accepts one micro-instruction per handshake. It drives the mux select,
// allows one settle cycle, samples the mux output and applies
// LOAD/ADD/SUB/AND into an 8-bit accumulator with carry and zero flags.
// A one-cycle done pulse marks each completed instruction.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   instr[7:0]   micro-instruction: [7:6] opcode, [5:4] source select,
//                [3:0] reserved (ignored)
//   instr_valid  instr is valid this cycle
//   instr_ready  controller is idle and can accept an instruction
//   sel[1:0]     operand mux select (00=a, 01=b, 10=c, 11=d)
//   mux_o[7:0]   data returned from the operand mux
//   acc[7:0]     accumulator
//   carry        carry (ADD) / borrow (SUB) flag
//   zero         accumulator-zero flag
//   done         one-cycle pulse when an instruction completes
//
// Build option:
//   OPSEL_ZERO_FLAG_EN  when defined, zero tracks (acc == 0). When undefined,
//                       zero is tied low and no compare logic is built.
// ----------------------------------------------------------------------------
module operand_select_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [1:0] sel,
    input  logic [7:0] mux_o,
    output logic [7:0] acc,
    output logic       carry,
    output logic       zero,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SELECT = 2'b01,
        EXEC   = 2'b10,
        DONE   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_AND  = 2'b11
    } op_t;

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic       done_q, done_d;
    logic       handshake;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic       instr_unused;

    // The reserved instruction bits carry no meaning for this block.
    assign instr_unused = ^instr[3:0];

    assign handshake = instr_valid && (state_q == IDLE);

    // Bit 8 of the 9-bit difference is the borrow (set iff acc < mux_o).
    assign sum9  = {1'b0, acc_q} + {1'b0, mux_o};
    assign diff9 = {1'b0, acc_q} - {1'b0, mux_o};

`ifdef OPSEL_ZERO_FLAG_EN
    logic zero_q, zero_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        carry_d = carry_q;
`ifdef OPSEL_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        // done is registered so it is high exactly during the DONE cycle.
        done_d  = (state_q == EXEC);

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = SELECT;
                    op_d    = op_t'(instr[7:6]);
                    sel_d   = instr[5:4];
                end
            end
            // Mux output settles this cycle; it is not sampled here.
            SELECT: state_d = EXEC;
            EXEC: begin
                state_d = DONE;
                case (op_q)
                    OP_LOAD: acc_d = mux_o;
                    OP_ADD: begin
                        acc_d   = sum9[7:0];
                        carry_d = sum9[8];
                    end
                    OP_SUB: begin
                        acc_d   = diff9[7:0];
                        carry_d = diff9[8];
                    end
                    default: begin
                        acc_d   = acc_q & mux_o;
                        carry_d = 1'b0;
                    end
                endcase
`ifdef OPSEL_ZERO_FLAG_EN
                zero_d = (acc_d == 8'h00);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            sel_q   <= 2'b00;
            acc_q   <= 8'h00;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

`ifdef OPSEL_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end
    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

    assign instr_ready = (state_q == IDLE);
    assign sel         = sel_q;
    assign acc         = acc_q;
    assign carry       = carry_q;
    assign done        = done_q;

endmodule

// File: tb/tb_operand_select_ctrl.sv
module tb_operand_select_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] sel;
    logic [7:0] mux_o;
    logic [7:0] acc;
    logic       carry;
    logic       zero;
    logic       done;

    int checks;
    int errors;

`ifdef OPSEL_ZERO_FLAG_EN
    localparam logic ZF_EN = 1'b1;
`else
    localparam logic ZF_EN = 1'b0;
`endif

    operand_select_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .sel         (sel),
        .mux_o       (mux_o),
        .acc         (acc),
        .carry       (carry),
        .zero        (zero),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand mux with fixed inputs a=0x10, b=0x20, c=0xF0, d=0x01.
    always_comb begin
        case (sel)
            2'b00:   mux_o = 8'h10;
            2'b01:   mux_o = 8'h20;
            2'b10:   mux_o = 8'hF0;
            default: mux_o = 8'h01;
        endcase
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic run_instr(input string name, input logic [7:0] ins,
                             input logic [7:0] e_acc, input logic e_carry,
                             input logic e_zero);
        chk({name, ".ready_N"}, {8'h0, instr_ready}, 9'h1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;                      // cycle N+1 (SELECT)
        instr_valid = 1'b0;
        chk({name, ".sel"}, {7'h0, sel}, {7'h0, ins[5:4]});
        chk({name, ".ready_N1"}, {8'h0, instr_ready}, 9'h0);
        chk({name, ".done_N1"}, {8'h0, done}, 9'h0);
        @(posedge clk); #1;                      // cycle N+2 (EXEC)
        @(posedge clk); #1;                      // cycle N+3 (DONE)
        chk({name, ".done_N3"}, {8'h0, done}, 9'h1);
        chk({name, ".acc"}, {1'b0, acc}, {1'b0, e_acc});
        chk({name, ".carry"}, {8'h0, carry}, {8'h0, e_carry});
        chk({name, ".zero"}, {8'h0, zero}, {8'h0, e_zero});
        @(posedge clk); #1;                      // cycle N+4 (IDLE)
        chk({name, ".done_N4"}, {8'h0, done}, 9'h0);
        chk({name, ".ready_N4"}, {8'h0, instr_ready}, 9'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_count;
        int hs_first;
        int hs_second;
        int ready_low;
        int done_cnt;
        logic hs;

        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        instr       = 8'h00;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst.acc",   {1'b0, acc},        9'h000);
        chk("rst.sel",   {7'h0, sel},        9'h000);
        chk("rst.carry", {8'h0, carry},      9'h000);
        chk("rst.zero",  {8'h0, zero},       9'h000);
        chk("rst.done",  {8'h0, done},       9'h000);
        chk("rst.ready", {8'h0, instr_ready}, 9'h001);

        run_instr("load_c", 8'h20, 8'hF0, 1'b0, 1'b0);
        run_instr("add_c",  8'h60, 8'hE0, 1'b1, 1'b0);
        run_instr("load_d", 8'h30, 8'h01, 1'b1, 1'b0);   // LOAD keeps carry
        run_instr("sub_d",  8'hB0, 8'h00, 1'b0, ZF_EN);
        run_instr("load_a", 8'h00, 8'h10, 1'b0, 1'b0);
        run_instr("sub_b",  8'h90, 8'hF0, 1'b1, 1'b0);   // 0x10-0x20 borrows
        run_instr("and_a",  8'hC0, 8'h10, 1'b0, 1'b0);

        // Two queued instructions with instr_valid held high:
        // LOAD a (acc=0x10) then ADD a (acc=0x20).
        hs_count    = 0;
        hs_first    = -1;
        hs_second   = -1;
        ready_low   = 0;
        done_cnt    = 0;
        instr       = 8'h00;
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (done) done_cnt++;
            if (!instr_ready && hs_count == 1) ready_low++;
            hs = instr_valid && instr_ready;
            @(posedge clk); #1;
            if (hs) begin
                hs_count++;
                if (hs_count == 1) begin
                    hs_first = cyc;
                    instr    = 8'h40;
                end else begin
                    hs_second   = cyc;
                    instr_valid = 1'b0;
                end
            end
        end
        chk("b2b.hs_count",  hs_count[8:0],                 9'd2);
        chk("b2b.hs_gap",    9'(hs_second - hs_first),      9'd4);
        chk("b2b.ready_low", ready_low[8:0],                9'd3);
        chk("b2b.done_cnt",  done_cnt[8:0],                 9'd2);
        chk("b2b.acc",       {1'b0, acc},                   9'h020);
        chk("b2b.carry",     {8'h0, carry},                 9'h000);

        // Reset during EXEC of ADD b aborts the instruction.
        run_instr("load_c2", 8'h20, 8'hF0, 1'b0, 1'b0);
        instr       = 8'h50;
        instr_valid = 1'b1;
        @(posedge clk); #1;                      // SELECT
        instr_valid = 1'b0;
        @(posedge clk); #1;                      // EXEC
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort.done",  {8'h0, done},        9'h000);
        chk("abort.acc",   {1'b0, acc},         9'h000);
        chk("abort.sel",   {7'h0, sel},         9'h000);
        chk("abort.carry", {8'h0, carry},       9'h000);
        chk("abort.zero",  {8'h0, zero},        9'h000);
        chk("abort.ready", {8'h0, instr_ready}, 9'h001);
        @(posedge clk); #1;
        chk("abort.done2",  {8'h0, done},        9'h000);
        chk("abort.ready2", {8'h0, instr_ready}, 9'h001);
        chk("abort.acc2",   {1'b0, acc},         9'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_select_ctrl.md
# operand_select_ctrl

Sequencing controller placed around the 8-bit 4:1 operand multiplexer in the datapath. Accepts one 8-bit micro-instruction per handshake, drives the mux's 2-bit select, captures the mux output one settle cycle later, and applies a LOAD/ADD/SUB/AND operation into an 8-bit accumulator with carry and zero flags. Emits a one-cycle `done` pulse per completed instruction.

## Interface
- No parameters. Data width fixed at 8, select width fixed at 2.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `instr` input 8: micro-instruction. Bits [7:6] are the opcode; [5:4] are the source select; [3:0] are reserved and ignored.
- `instr_valid` input 1: `instr` is valid this cycle.
- `instr_ready` output 1: high only in IDLE; transfer occurs when `instr_valid & instr_ready` at a rising edge.
- `sel` output 2: select for the operand mux (00=a, 01=b, 10=c, 11=d).
- `mux_o` input 8: data returned from the operand mux.
- `acc` output 8: accumulator.
- `carry` output 1: carry (ADD) or borrow (SUB) flag.
- `zero` output 1: accumulator-zero flag (see Configuration).
- `done` output 1: one-cycle pulse when an instruction completes.

## Operation
- FSM states: IDLE, SELECT, EXEC, DONE.
  - IDLE goes to SELECT on handshake; otherwise it stays in IDLE.
  - SELECT always goes to EXEC.
  - EXEC always goes to DONE.
  - DONE always goes to IDLE.
- On handshake, latch the opcode and select field. `sel` is registered from `instr[5:4]` and holds until the next handshake.
- In SELECT, the mux output settles; `mux_o` is not sampled.
- At the rising edge ending EXEC, `mux_o` is sampled and the operation is applied:
  - 00 LOAD: `acc` = `mux_o`; `carry` is unchanged.
  - 01 ADD: {`carry`,`acc`} = `acc` + `mux_o`, computed as 9-bit; `carry` = bit 8.
  - 10 SUB: {`carry`,`acc`} = `acc` − `mux_o`, computed as 9-bit; `carry` = 1 iff `acc` < `mux_o` (borrow).
  - 11 AND: `acc` = `acc` & `mux_o`; `carry` is cleared.
- `zero` updates at the same edge as `acc`, to (new `acc` == 0).
- `done` is registered. It is high for exactly the DONE cycle.
- `instr_valid` outside IDLE is ignored. The upstream source holds `instr` until it sees `instr_ready`.
- Reset values: state IDLE, `sel`=00, `acc`=0x00, `carry`=0, `zero`=0, `done`=0, `instr_ready`=1 in the first cycle after reset.
- Reset in any state: the instruction is aborted with no accumulator update, `done` is not pulsed, and all outputs return to their reset values at that edge.

## Timing
- Handshake at edge N.
- `sel` valid during cycle N+1 (SELECT).
- EXEC runs during N+2. `acc`, `carry` and `zero` are visible from N+3.
- `done`=1 during N+3.
- `instr_ready`=1 from N+4.
- Maximum throughput: one instruction per 4 cycles. Back-to-back handshakes occur at edges N and N+4.
- `mux_o` must be stable from the start of N+2 up to the edge ending N+2.

## Configuration
- `OPSEL_ZERO_FLAG_EN` defined: the `zero` flag is computed as described in Operation.
- `OPSEL_ZERO_FLAG_EN` undefined: `zero` is tied to 0 and no compare logic is built. All other behaviour is identical.

## Test plan
Mux inputs for all scenarios: a=0x10, b=0x20, c=0xF0, d=0x01.
- LOAD c (`instr`=0x20) from reset → `sel`=10 at N+1; `acc`=0xF0, `carry`=0, `zero`=0, `done`=1 at N+3; `instr_ready`=1 at N+4.
- Then ADD c (0x60) → `acc`=0xE0, `carry`=1.
- LOAD d (0x30), then SUB d (0xB0) → `acc`=0x00, `carry`=0, `zero`=1. With the macro undefined, `zero` stays 0.
- LOAD a (0x00), then SUB b (0x90) → `acc`=0xF0, `carry`=1 (borrow). Then AND a (0xC0) → `acc`=0x10, `carry`=0.
- `instr_valid` held high with two queued instructions → `instr_ready` is low for 3 cycles between them; handshakes occur exactly 4 cycles apart and each instruction gets exactly one `done`.
- After `acc`=0xF0, drive `rst_n`=0 for one cycle during EXEC of ADD b → no `done` pulse; `acc`=0x00, `sel`=00, `carry`=0 after that edge; `instr_ready`=1 the next cycle.
